mc_port_responder: RTL and testbench

MC_PORT_RESPONDER -- requirements
Module: mc_port_responder

---
 rtl/mc_resp_pkg.sv | 29 ++
 rtl/mc_port_responder_if.sv | 45 ++++
 rtl/mc_resp_fifo.sv | 59 +++++
 rtl/mc_port_responder.sv | 188 ++++++++++++++++++
 tb/tb_mc_port_responder.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_resp_pkg.sv
// Shared encodings, widths and the response payload layout for the memory-controller port responder.
package mc_resp_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CMD_W  = 3;
    localparam int unsigned SCMD_W = 4;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned VADR_W = 48;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [CMD_W-1:0] {
        RQ_RD = 3'd1,
        RQ_WR = 3'd2
    } rq_cmd_e;

    typedef enum logic [CMD_W-1:0] {
        RS_RDDATA = 3'd2,
        RS_WRCMP  = 3'd3
    } rs_cmd_e;

    localparam logic [SIZE_W-1:0] SIZE_8B = 2'd3;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [SCMD_W-1:0] scmd;
        logic [DATA_W-1:0] data;
    } rs_payload_t;

endpackage

// File: rtl/mc_port_responder_if.sv
// Request, response and flush signals between a requester (master) and the port responder (slave).
interface mc_port_responder_if
    import mc_resp_pkg::*;
#(
    parameter int unsigned RTNCTL_WIDTH = 32
) ();

    logic                    mc_rq_vld;
    logic [CMD_W-1:0]        mc_rq_cmd;
    logic [SCMD_W-1:0]       mc_rq_scmd;
    logic [SIZE_W-1:0]       mc_rq_size;
    logic [VADR_W-1:0]       mc_rq_vadr;
    logic [DATA_W-1:0]       mc_rq_data;
    logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
    logic                    mc_rq_stall;

    logic                    mc_rs_vld;
    logic [CMD_W-1:0]        mc_rs_cmd;
    logic [SCMD_W-1:0]       mc_rs_scmd;
    logic [DATA_W-1:0]       mc_rs_data;
    logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
    logic                    mc_rs_stall;

    logic                    mc_rq_flush;
    logic                    mc_rs_flush_cmplt;

    modport master (
        output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl,
        input  mc_rq_stall,
        input  mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
        output mc_rs_stall,
        output mc_rq_flush,
        input  mc_rs_flush_cmplt
    );

    modport slave (
        input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl,
        output mc_rq_stall,
        output mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
        input  mc_rs_stall,
        input  mc_rq_flush,
        output mc_rs_flush_cmplt
    );

endinterface

// File: rtl/mc_resp_fifo.sv
// Synchronous response FIFO with registered empty/full flags and a combinational head-of-queue read.
module mc_resp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata_c,
    output logic             o_empty,
    output logic             o_full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             push_c, pop_c;

    // Pointers carry one wrap bit so equal indices can be told apart as empty or full.
    always_comb begin
        push_c   = i_push && !full_q;
        pop_c    = i_pop && !empty_q;
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_c);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop_c);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c && !i_reset) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
        end
    end

    assign o_rdata_c = mem_q[rd_ptr_q[AW-1:0]];
    assign o_empty   = empty_q;
    assign o_full    = full_q;

endmodule

// File: rtl/mc_port_responder.sv
// Memory-controller port responder: executes 8-byte reads/writes against a local store and returns
// in-order responses through a fixed-latency pipeline and a response FIFO.
module mc_port_responder
    import mc_resp_pkg::*;
#(
    parameter int unsigned RTNCTL_WIDTH = 32,
    parameter int unsigned MEM_AW       = 10,
    parameter int unsigned LAT          = 4,
    parameter int unsigned DEPTH        = 8
) (
    input  logic                 clk,
    input  logic                 i_reset,
    mc_port_responder_if.slave   bus,
    output logic                 o_err,
    output logic [CNT_W-1:0]     o_rd_cnt,
    output logic [CNT_W-1:0]     o_wr_cnt
);

    localparam int unsigned IW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $bits(rs_payload_t);
    localparam int unsigned FW = RTNCTL_WIDTH + PW;

    logic is_rd_c, is_wr_c, cmd_ok_c, full_c, accept_c, overflow_c, bad_req_c, pop_c;

    logic                    s0_vld_q, s0_vld_d;
    logic                    s0_wr_q, s0_wr_d;
    logic [MEM_AW-1:0]       s0_addr_q, s0_addr_d;
    logic [DATA_W-1:0]       s0_wdata_q, s0_wdata_d;
    logic [RTNCTL_WIDTH-1:0] s0_rtn_q, s0_rtn_d;

    logic [DATA_W-1:0]       mem_q [2**MEM_AW];
    logic [DATA_W-1:0]       mem_rdata_c;

    logic                    p_vld_q [1:LAT-1];
    logic                    p_vld_d [1:LAT-1];
    rs_payload_t             p_pl_q  [1:LAT-1];
    rs_payload_t             p_pl_d  [1:LAT-1];
    logic [RTNCTL_WIDTH-1:0] p_rtn_q [1:LAT-1];
    logic [RTNCTL_WIDTH-1:0] p_rtn_d [1:LAT-1];

    logic [FW-1:0]           fifo_rdata_c;
    logic                    fifo_empty;
    logic                    unused_fifo_full;

    logic                    rs_vld_q, rs_vld_d;
    rs_payload_t             rs_pl_q, rs_pl_d;
    logic [RTNCTL_WIDTH-1:0] rs_rtn_q, rs_rtn_d;

    logic [IW-1:0]           inflight_q, inflight_d;
    logic                    stall_q, stall_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
    logic                    flush_pend_q, flush_pend_d;
    logic                    cmplt_q, cmplt_d;

    // Request classification; inflight already at DEPTH means the FIFO has no room reserved.
    always_comb begin
        is_rd_c    = (bus.mc_rq_cmd == RQ_RD);
        is_wr_c    = (bus.mc_rq_cmd == RQ_WR);
        cmd_ok_c   = is_rd_c || is_wr_c;
        full_c     = (inflight_q == IW'(DEPTH));
        accept_c   = bus.mc_rq_vld && cmd_ok_c && !full_c;
        overflow_c = bus.mc_rq_vld && cmd_ok_c && full_c;
        bad_req_c  = bus.mc_rq_vld && (!cmd_ok_c || (bus.mc_rq_size != SIZE_8B));
        pop_c      = !fifo_empty && !bus.mc_rs_stall;
    end

    assign mem_rdata_c = mem_q[s0_addr_q];

    // Store is written the cycle after acceptance, so a following read sees the new word.
    always_ff @(posedge clk) begin
        if (s0_vld_q && s0_wr_q && !i_reset) begin
            mem_q[s0_addr_q] <= s0_wdata_q;
        end
    end

    always_comb begin
        s0_vld_d   = accept_c;
        s0_wr_d    = is_wr_c;
        s0_addr_d  = bus.mc_rq_vadr[MEM_AW+2:3];
        s0_wdata_d = bus.mc_rq_data;
        s0_rtn_d   = bus.mc_rq_rtnctl;

        p_vld_d[1]      = s0_vld_q;
        p_pl_d[1].cmd   = s0_wr_q ? RS_WRCMP : RS_RDDATA;
        p_pl_d[1].scmd  = '0;
        p_pl_d[1].data  = s0_wr_q ? '0 : mem_rdata_c;
        p_rtn_d[1]      = s0_rtn_q;
        for (int unsigned i = 2; i < LAT; i++) begin
            p_vld_d[i] = p_vld_q[i-1];
            p_pl_d[i]  = p_pl_q[i-1];
            p_rtn_d[i] = p_rtn_q[i-1];
        end

        rs_vld_d = pop_c;
        rs_pl_d  = rs_pl_q;
        rs_rtn_d = rs_rtn_q;
        if (pop_c) begin
            rs_pl_d  = fifo_rdata_c[PW-1:0];
            rs_rtn_d = fifo_rdata_c[FW-1:PW];
        end

        inflight_d   = inflight_q + IW'(accept_c) - IW'(pop_c);
        stall_d      = (inflight_q >= IW'(DEPTH - 2));
        err_d        = err_q || bad_req_c || overflow_c;
        rd_cnt_d     = rd_cnt_q + CNT_W'(accept_c && is_rd_c);
        wr_cnt_d     = wr_cnt_q + CNT_W'(accept_c && is_wr_c);
        cmplt_d      = flush_pend_q && (inflight_q == '0);
        flush_pend_d = (flush_pend_q && !cmplt_d) || bus.mc_rq_flush;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            s0_vld_q     <= 1'b0;
            s0_wr_q      <= 1'b0;
            s0_addr_q    <= '0;
            s0_wdata_q   <= '0;
            s0_rtn_q     <= '0;
            for (int unsigned i = 1; i < LAT; i++) begin
                p_vld_q[i] <= 1'b0;
                p_pl_q[i]  <= '0;
                p_rtn_q[i] <= '0;
            end
            rs_vld_q     <= 1'b0;
            rs_pl_q      <= '0;
            rs_rtn_q     <= '0;
            inflight_q   <= '0;
            stall_q      <= 1'b0;
            err_q        <= 1'b0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            flush_pend_q <= 1'b0;
            cmplt_q      <= 1'b0;
        end else begin
            s0_vld_q     <= s0_vld_d;
            s0_wr_q      <= s0_wr_d;
            s0_addr_q    <= s0_addr_d;
            s0_wdata_q   <= s0_wdata_d;
            s0_rtn_q     <= s0_rtn_d;
            for (int unsigned i = 1; i < LAT; i++) begin
                p_vld_q[i] <= p_vld_d[i];
                p_pl_q[i]  <= p_pl_d[i];
                p_rtn_q[i] <= p_rtn_d[i];
            end
            rs_vld_q     <= rs_vld_d;
            rs_pl_q      <= rs_pl_d;
            rs_rtn_q     <= rs_rtn_d;
            inflight_q   <= inflight_d;
            stall_q      <= stall_d;
            err_q        <= err_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            flush_pend_q <= flush_pend_d;
            cmplt_q      <= cmplt_d;
        end
    end

    mc_resp_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .i_reset   (i_reset),
        .i_push    (p_vld_q[LAT-1]),
        .i_wdata   ({p_rtn_q[LAT-1], p_pl_q[LAT-1]}),
        .i_pop     (pop_c),
        .o_rdata_c (fifo_rdata_c),
        .o_empty   (fifo_empty),
        .o_full    (unused_fifo_full)
    );

    // Sub-command and out-of-range address bits play no part in execution.
    logic unused_rq_bits;
    assign unused_rq_bits = ^{bus.mc_rq_scmd, bus.mc_rq_vadr[VADR_W-1:MEM_AW+3], bus.mc_rq_vadr[2:0]};

    assign bus.mc_rq_stall       = stall_q;
    assign bus.mc_rs_vld         = rs_vld_q;
    assign bus.mc_rs_cmd         = rs_pl_q.cmd;
    assign bus.mc_rs_scmd        = rs_pl_q.scmd;
    assign bus.mc_rs_data        = rs_pl_q.data;
    assign bus.mc_rs_rtnctl      = rs_rtn_q;
    assign bus.mc_rs_flush_cmplt = cmplt_q;
    assign o_err                 = err_q;
    assign o_rd_cnt              = rd_cnt_q;
    assign o_wr_cnt              = wr_cnt_q;

endmodule

// File: tb/tb_mc_port_responder.sv
// Directed bench for mc_port_responder: latency, ordering, backpressure, flush, errors and reset.
module tb_mc_port_responder;

    typedef struct {
        logic [2:0]  cmd;
        logic [3:0]  scmd;
        logic [63:0] data;
        logic [31:0] rtn;
        int          cyc;
    } rs_rec_t;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        o_err;
    logic [31:0] o_rd_cnt, o_wr_cnt;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    rs_rec_t     rsq[$];
    int          flq[$];

    mc_port_responder_if #(.RTNCTL_WIDTH(32)) bus ();

    mc_port_responder #(
        .RTNCTL_WIDTH (32),
        .MEM_AW       (10),
        .LAT          (4),
        .DEPTH        (8)
    ) dut (
        .clk      (clk),
        .i_reset  (i_reset),
        .bus      (bus),
        .o_err    (o_err),
        .o_rd_cnt (o_rd_cnt),
        .o_wr_cnt (o_wr_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every issued response and completion pulse with the edge count that produced it.
    always @(negedge clk) begin
        if (bus.mc_rs_vld === 1'b1) begin
            rsq.push_back('{cmd: bus.mc_rs_cmd, scmd: bus.mc_rs_scmd, data: bus.mc_rs_data,
                            rtn: bus.mc_rs_rtnctl, cyc: cyc});
        end
        if (bus.mc_rs_flush_cmplt === 1'b1) flq.push_back(cyc);
    end

    task automatic drive_rq(input logic [2:0] cmd, input logic [1:0] size, input logic [47:0] vadr,
                            input logic [63:0] data, input logic [31:0] rtn);
        bus.mc_rq_vld    = 1'b1;
        bus.mc_rq_cmd    = cmd;
        bus.mc_rq_scmd   = 4'd0;
        bus.mc_rq_size   = size;
        bus.mc_rq_vadr   = vadr;
        bus.mc_rq_data   = data;
        bus.mc_rq_rtnctl = rtn;
    endtask

    task automatic idle_rq();
        bus.mc_rq_vld = 1'b0;
        bus.mc_rq_cmd = 3'd0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic apply_reset();
        idle_rq();
        bus.mc_rq_flush = 1'b0;
        bus.mc_rs_stall = 1'b0;
        i_reset = 1'b1;
        wait_cycles(2);
        i_reset = 1'b0;
        wait_cycles(1);
        rsq.delete();
        flq.delete();
    endtask

    task automatic wait_rsp(input int want, input int budget, input string name);
        for (int i = 0; i < budget && rsq.size() < want; i++) @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (rsq.size() != want) begin
            n_fail++;
            $display("FAIL %s response count: got %0d expected %0d", name, rsq.size(), want);
        end
    endtask

    task automatic test_reset();
        wait_cycles(2);
        n_tests++;
        if ({bus.mc_rq_stall, bus.mc_rs_vld, bus.mc_rs_flush_cmplt, o_err} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.mc_rq_stall, bus.mc_rs_vld, bus.mc_rs_flush_cmplt, o_err});
        end
        n_tests++;
        if ({bus.mc_rs_cmd, bus.mc_rs_scmd, bus.mc_rs_data, bus.mc_rs_rtnctl} !== '0) begin
            n_fail++;
            $display("FAIL reset_rs_fields: got cmd %0h data %0h rtn %0h expected 0",
                     bus.mc_rs_cmd, bus.mc_rs_data, bus.mc_rs_rtnctl);
        end
        n_tests++;
        if ({o_rd_cnt, o_wr_cnt} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got rd %0d wr %0d expected 0", o_rd_cnt, o_wr_cnt);
        end
        i_reset = 1'b0;
        wait_cycles(1);
    endtask

    task automatic test_write_read();
        int a;
        rsq.delete();
        drive_rq(3'd2, 2'd3, 48'h40, 64'hDEAD_BEEF_0000_0001, 32'd5);
        @(negedge clk);
        a = cyc;
        idle_rq();
        wait_rsp(1, 20, "wr_basic");
        if (rsq.size() == 1) begin
            n_tests++;
            if (rsq[0].cmd !== 3'd3 || rsq[0].data !== 64'd0 || rsq[0].rtn !== 32'd5 || rsq[0].scmd !== 4'd0) begin
                n_fail++;
                $display("FAIL wrcmp_fields: got cmd %0h data %0h rtn %0d expected cmd 3 data 0 rtn 5",
                         rsq[0].cmd, rsq[0].data, rsq[0].rtn);
            end
            n_tests++;
            if (rsq[0].cyc - a != 5) begin
                n_fail++;
                $display("FAIL wrcmp_latency: got %0d expected 5", rsq[0].cyc - a);
            end
        end
        rsq.delete();
        drive_rq(3'd1, 2'd3, 48'h40, 64'd0, 32'd6);
        @(negedge clk);
        a = cyc;
        idle_rq();
        wait_rsp(1, 20, "rd_basic");
        if (rsq.size() == 1) begin
            n_tests++;
            if (rsq[0].cmd !== 3'd2 || rsq[0].data !== 64'hDEAD_BEEF_0000_0001 || rsq[0].rtn !== 32'd6) begin
                n_fail++;
                $display("FAIL rddata_fields: got cmd %0h data %0h rtn %0d expected cmd 2 data deadbeef00000001 rtn 6",
                         rsq[0].cmd, rsq[0].data, rsq[0].rtn);
            end
            n_tests++;
            if (rsq[0].cyc - a != 5) begin
                n_fail++;
                $display("FAIL rddata_latency: got %0d expected 5", rsq[0].cyc - a);
            end
        end
    endtask

    task automatic test_back_to_back();
        int a;
        apply_reset();
        drive_rq(3'd2, 2'd3, 48'h80, 64'hA5, 32'd20);
        @(negedge clk);
        a = cyc;
        drive_rq(3'd1, 2'd3, 48'h80, 64'd0, 32'd21);
        @(negedge clk);
        idle_rq();
        wait_rsp(2, 20, "b2b");
        if (rsq.size() == 2) begin
            n_tests++;
            if (rsq[0].cmd !== 3'd3 || rsq[0].rtn !== 32'd20 || rsq[0].cyc - a != 5) begin
                n_fail++;
                $display("FAIL b2b_wrcmp: got cmd %0h rtn %0d lat %0d expected cmd 3 rtn 20 lat 5",
                         rsq[0].cmd, rsq[0].rtn, rsq[0].cyc - a);
            end
            n_tests++;
            if (rsq[1].cmd !== 3'd2 || rsq[1].data !== 64'hA5 || rsq[1].rtn !== 32'd21 || rsq[1].cyc - a != 6) begin
                n_fail++;
                $display("FAIL b2b_rddata: got cmd %0h data %0h rtn %0d lat %0d expected cmd 2 data a5 rtn 21 lat 6",
                         rsq[1].cmd, rsq[1].data, rsq[1].rtn, rsq[1].cyc - a);
            end
        end
        n_tests++;
        if (o_wr_cnt !== 32'd1 || o_rd_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL b2b_counters: got wr %0d rd %0d expected 1 1", o_wr_cnt, o_rd_cnt);
        end
    endtask

    task automatic test_stall();
        int sent = 0;
        int first_stall_sent = -1;
        rsq.delete();
        bus.mc_rs_stall = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (bus.mc_rq_stall === 1'b1 && first_stall_sent < 0) first_stall_sent = sent;
            if (bus.mc_rq_stall !== 1'b1 && sent < 10) begin
                drive_rq(3'd1, 2'd3, (sent % 2 == 0) ? 48'h40 : 48'h80, 64'd0, 32'(100 + sent));
                sent++;
            end else begin
                idle_rq();
            end
            @(negedge clk);
        end
        n_tests++;
        if (first_stall_sent != 7 || sent != 7) begin
            n_fail++;
            $display("FAIL stall_holdoff: got sent %0d at stall, %0d total expected 7 7", first_stall_sent, sent);
        end
        n_tests++;
        if (rsq.size() != 0 || bus.mc_rq_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_window: got %0d responses rq_stall %b expected 0 responses rq_stall 1",
                     rsq.size(), bus.mc_rq_stall);
        end
        bus.mc_rs_stall = 1'b0;
        for (int c = 0; c < 200 && (sent < 10 || rsq.size() < 10); c++) begin
            if (bus.mc_rq_stall !== 1'b1 && sent < 10) begin
                drive_rq(3'd1, 2'd3, (sent % 2 == 0) ? 48'h40 : 48'h80, 64'd0, 32'(100 + sent));
                sent++;
            end else begin
                idle_rq();
            end
            @(negedge clk);
        end
        idle_rq();
        wait_rsp(10, 10, "stall");
        for (int i = 0; i < rsq.size() && i < 10; i++) begin
            n_tests++;
            if (rsq[i].cmd !== 3'd2 || rsq[i].rtn !== 32'(100 + i) ||
                rsq[i].data !== ((i % 2 == 0) ? 64'hDEAD_BEEF_0000_0001 : 64'hA5)) begin
                n_fail++;
                $display("FAIL stall_rsp%0d: got cmd %0h rtn %0d data %0h expected cmd 2 rtn %0d",
                         i, rsq[i].cmd, rsq[i].rtn, rsq[i].data, 100 + i);
            end
        end
        n_tests++;
        if (o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_err: got %b expected 0", o_err);
        end
    endtask

    task automatic test_flush();
        int a;
        rsq.delete();
        flq.delete();
        drive_rq(3'd2, 2'd3, 48'h100, 64'h11, 32'd30);
        @(negedge clk);
        a = cyc;
        drive_rq(3'd2, 2'd3, 48'h108, 64'h22, 32'd31);
        @(negedge clk);
        drive_rq(3'd2, 2'd3, 48'h110, 64'h33, 32'd32);
        @(negedge clk);
        idle_rq();
        bus.mc_rq_flush = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.mc_rq_flush = 1'b0;
        for (int i = 0; i < 30 && flq.size() == 0; i++) @(negedge clk);
        wait_cycles(10);
        n_tests++;
        if (rsq.size() != 3 || flq.size() != 1) begin
            n_fail++;
            $display("FAIL flush_counts: got %0d rsp %0d pulses expected 3 1", rsq.size(), flq.size());
        end
        if (rsq.size() == 3 && flq.size() == 1) begin
            n_tests++;
            if (rsq[2].cyc - a != 7 || rsq[2].rtn !== 32'd32) begin
                n_fail++;
                $display("FAIL flush_last_wrcmp: got lat %0d rtn %0d expected 7 32", rsq[2].cyc - a, rsq[2].rtn);
            end
            n_tests++;
            if (flq[0] != rsq[2].cyc + 1) begin
                n_fail++;
                $display("FAIL flush_cmplt_time: got %0d expected %0d", flq[0], rsq[2].cyc + 1);
            end
        end
    endtask

    task automatic test_bad_cmd();
        apply_reset();
        drive_rq(3'd5, 2'd3, 48'h40, 64'd0, 32'd40);
        @(negedge clk);
        idle_rq();
        wait_cycles(10);
        n_tests++;
        if (o_err !== 1'b1 || rsq.size() != 0) begin
            n_fail++;
            $display("FAIL badcmd: got err %b %0d rsp expected err 1 0 rsp", o_err, rsq.size());
        end
        n_tests++;
        if (o_rd_cnt !== 32'd0 || o_wr_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL badcmd_counters: got rd %0d wr %0d expected 0 0", o_rd_cnt, o_wr_cnt);
        end
        apply_reset();
        drive_rq(3'd1, 2'd0, 48'hFFFF_0000_0080, 64'd0, 32'd9);
        @(negedge clk);
        idle_rq();
        wait_rsp(1, 20, "badsize");
        n_tests++;
        if (o_err !== 1'b1 || o_rd_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL badsize_status: got err %b rd %0d expected 1 1", o_err, o_rd_cnt);
        end
        if (rsq.size() == 1) begin
            n_tests++;
            if (rsq[0].data !== 64'hA5 || rsq[0].rtn !== 32'd9) begin
                n_fail++;
                $display("FAIL badsize_data: got %0h rtn %0d expected a5 9", rsq[0].data, rsq[0].rtn);
            end
        end
    endtask

    task automatic test_reset_midflight();
        rsq.delete();
        for (int i = 0; i < 4; i++) begin
            drive_rq((i % 2 == 0) ? 3'd2 : 3'd1, 2'd3, 48'h200, 64'h77, 32'(50 + i));
            @(negedge clk);
        end
        idle_rq();
        i_reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus.mc_rq_stall, bus.mc_rs_vld, bus.mc_rs_flush_cmplt, o_err} !== 4'b0 ||
            {bus.mc_rs_cmd, bus.mc_rs_scmd, bus.mc_rs_data, bus.mc_rs_rtnctl} !== '0 ||
            {o_rd_cnt, o_wr_cnt} !== 64'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got flags %b rtn %0d rd %0d wr %0d expected all 0",
                     {bus.mc_rq_stall, bus.mc_rs_vld, bus.mc_rs_flush_cmplt, o_err},
                     bus.mc_rs_rtnctl, o_rd_cnt, o_wr_cnt);
        end
        i_reset = 1'b0;
        wait_cycles(20);
        n_tests++;
        if (rsq.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_no_rsp: got %0d expected 0", rsq.size());
        end
        drive_rq(3'd1, 2'd3, 48'h40, 64'd0, 32'd7);
        @(negedge clk);
        idle_rq();
        wait_rsp(1, 20, "midreset_read");
        if (rsq.size() == 1) begin
            n_tests++;
            if (rsq[0].data !== 64'hDEAD_BEEF_0000_0001 || rsq[0].rtn !== 32'd7) begin
                n_fail++;
                $display("FAIL midreset_mem: got %0h rtn %0d expected deadbeef00000001 7", rsq[0].data, rsq[0].rtn);
            end
        end
    endtask

    initial begin
        idle_rq();
        bus.mc_rq_scmd   = 4'd0;
        bus.mc_rq_size   = 2'd3;
        bus.mc_rq_vadr   = '0;
        bus.mc_rq_data   = '0;
        bus.mc_rq_rtnctl = '0;
        bus.mc_rs_stall  = 1'b0;
        bus.mc_rq_flush  = 1'b0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_stall();
        test_flush();
        test_bad_cmd();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
